sigmoid_share_arbiter: RTL and testbench



---
 rtl/sigmoid_share_arbiter_pkg.sv | 24 ++
 rtl/sigmoid_lut_interp.sv | 24 ++
 rtl/sigmoid_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_sigmoid_share_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_share_arbiter_pkg.sv
// Shared constants, sigmoid LUT and stage-A record for the shared sigmoid datapath.
package sig_share_pkg;

  localparam int Z_W      = 8;
  localparam int A_W      = 8;
  localparam int FRAC_W   = 4;
  // Widest requester tag supported (N_REQ up to 8); the top narrows it to ID_W.
  localparam int MAX_ID_W = 3;

  // round(64 * sigmoid(k - 8)) for k = 0..16; entry 16 is the upper end of the last segment.
  localparam logic [A_W-1:0] SIG_T [0:16] = '{
    8'd0,  8'd0,  8'd0,  8'd0,  8'd1,  8'd3,  8'd8,  8'd17,
    8'd32, 8'd47, 8'd56, 8'd61, 8'd63, 8'd64, 8'd64, 8'd64,
    8'd64
  };

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [A_W-1:0]      base;
    logic [A_W-1:0]      next;
    logic [FRAC_W-1:0]   rem;
  } stage_a_t;

endpackage

// File: rtl/sigmoid_lut_interp.sv
// Combinational segment lookup: splits a Q3.4 input into LUT segment endpoints
// and the fractional position inside the segment.
module sigmoid_lut_interp
  import sig_share_pkg::*;
(
  input  logic signed [Z_W-1:0]    z,
  output logic        [A_W-1:0]    base,
  output logic        [A_W-1:0]    next,
  output logic        [FRAC_W-1:0] rem
);

  logic [4:0] k;
  logic [4:0] k_nxt;

  // Flip the sign bit of the integer part so -8.0 maps to segment 0 and 7.x to segment 15.
  always_comb begin
    k     = {1'b0, ~z[7], z[6:4]};
    k_nxt = k + 5'd1;
    base  = SIG_T[k];
    next  = SIG_T[k_nxt];
    rem   = z[3:0];
  end

endmodule

// File: rtl/sigmoid_share_arbiter.sv
// Round-robin shared sigmoid unit: grants one requester per cycle into a
// two-stage lookup/interpolate pipeline and returns id-tagged results.
module sigmoid_share_arbiter
  import sig_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [Z_W*N_REQ-1:0]   req_z,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [A_W-1:0]         res_a,
  output logic                   busy
);

  // First valid requester after the last grant, wrapping modulo N_REQ.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                               input logic [ID_W-1:0]  last);
    logic [N_REQ-1:0] g;
    logic             found;
    logic [ID_W-1:0]  idx;
    g     = '0;
    found = 1'b0;
    for (int o = 1; o <= N_REQ; o++) begin
      idx = ID_W'((int'(last) + o) % N_REQ);
      if (!found && v[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // Linear interpolation inside one 16-step segment; result lies in [base, next].
  function automatic logic [A_W-1:0] interp(input stage_a_t s);
    logic signed [8:0]  d;
    logic signed [13:0] d14;
    logic signed [13:0] r14;
    logic signed [13:0] p;
    logic signed [8:0]  a9;
    d   = $signed({1'b0, s.next}) - $signed({1'b0, s.base});
    d14 = 14'(d);
    r14 = 14'({1'b0, s.rem});
    p   = d14 * r14;
    a9  = $signed({1'b0, s.base}) + 9'(p >>> 4);
    return A_W'(a9);
  endfunction

  logic                  s1_valid_q, s1_valid_d;
  stage_a_t              st_a_p1_q, st_a_p1_d;
  logic                  res_valid_q, res_valid_d;
  logic [ID_W-1:0]       res_id_q, res_id_d;
  logic [A_W-1:0]        res_a_q, res_a_d;
  logic [ID_W-1:0]       last_q, last_d;

  logic                  rb_load;
  logic                  can_grant;
  logic [N_REQ-1:0]      grant;
  logic [ID_W-1:0]       gid;
  logic signed [Z_W-1:0] z_sel;
  logic [A_W-1:0]        lut_base;
  logic [A_W-1:0]        lut_next;
  logic [FRAC_W-1:0]     lut_rem;

  sigmoid_lut_interp u_lut (
    .z    (z_sel),
    .base (lut_base),
    .next (lut_next),
    .rem  (lut_rem)
  );

  // Grant decision and index encode; nothing is granted while reset is held.
  always_comb begin
    rb_load   = !res_valid_q || res_ready;
    can_grant = !s1_valid_q || rb_load;
    grant     = (can_grant && !rst) ? rr_pick(req_valid, last_q) : '0;
    gid       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) gid = ID_W'(i);
    end
    z_sel     = $signed(req_z[int'(gid)*Z_W +: Z_W]);
  end

  // Next-state for pointer and both pipeline stages.
  always_comb begin
    last_d      = last_q;
    s1_valid_d  = s1_valid_q;
    st_a_p1_d   = st_a_p1_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_a_d     = res_a_q;
    // stage A: lookup of the granted operand
    if (|grant) begin
      last_d         = gid;
      s1_valid_d     = 1'b1;
      st_a_p1_d.id   = MAX_ID_W'(gid);
      st_a_p1_d.base = lut_base;
      st_a_p1_d.next = lut_next;
      st_a_p1_d.rem  = lut_rem;
    end else if (rb_load) begin
      s1_valid_d = 1'b0;
    end
    // stage B: interpolation into the result register
    if (rb_load) begin
      res_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_id_d = ID_W'(st_a_p1_q.id);
        res_a_d  = interp(st_a_p1_q);
      end
    end
  end

  // Control and visible result registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= ID_W'(N_REQ - 1);
      s1_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_a_q     <= '0;
    end else begin
      last_q      <= last_d;
      s1_valid_q  <= s1_valid_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_a_q     <= res_a_d;
    end
  end

  // Stage-A payload; only read while s1_valid_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    st_a_p1_q <= st_a_p1_d;
  end

  assign req_ready = grant;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_a     = res_a_q;
  assign busy      = s1_valid_q | res_valid_q;

endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// Bench for sigmoid_share_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sigmoid_share_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_z;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic           res_ready;
  logic [IDW-1:0] res_id;
  logic [7:0]     res_a;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int tbl [17];

  typedef struct { int id; int a; int age; } item_t;
  item_t q [$];
  int    m_last;
  int    waitc [N];

  always #5 clk = ~clk;

  sigmoid_share_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_z     (req_z),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_a     (res_a),
    .busy      (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Sigmoid of a Q3.4 value from segment arithmetic on the real-valued table.
  function automatic int model_a(input logic [7:0] z);
    int u, k, r;
    u = int'($signed(z)) + 128;
    k = u / 16;
    r = u % 16;
    return tbl[k] + ((tbl[k+1] - tbl[k]) * r) / 16;
  endfunction

  // Two-slot buffer: accepts when not full or when the consumer takes the head.
  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    int i;
    g = '0;
    if (q.size() < 2 || res_ready) begin
      for (int o = 1; o <= N; o++) begin
        i = (m_last + o) % N;
        if (req_valid[i]) begin
          g[i] = 1'b1;
          return g;
        end
      end
    end
    return g;
  endfunction

  // Per-cycle compare against the model, then advance the model across the next edge.
  initial begin
    logic [N-1:0] g;
    logic         ev;
    item_t        dummy;
    int           gi;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        m_last = N - 1;
        for (int i = 0; i < N; i++) waitc[i] = 0;
      end else begin
        g  = model_grant();
        ev = (q.size() > 0) && (q[0].age >= 2);
        chk("req_ready", int'(req_ready), int'(g));
        chk("res_valid", int'(res_valid), int'(ev));
        chk("busy", int'(busy), int'(q.size() > 0));
        if (ev) begin
          chk("res_id", int'(res_id), q[0].id);
          chk("res_a", int'(res_a), q[0].a);
        end
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && !g[i] && g != '0) begin
            waitc[i]++;
            checks++;
            if (waitc[i] > N - 1) begin
              errors++;
              $display("FAIL starvation req=%0d waited=%0d limit=%0d", i, waitc[i], N - 1);
            end
          end else if (!req_valid[i] || g[i]) begin
            waitc[i] = 0;
          end
        end
        if (ev && res_ready) dummy = q.pop_front();
        foreach (q[j]) q[j].age++;
        if (g != '0) begin
          gi = 0;
          for (int i = 0; i < N; i++) if (g[i]) gi = i;
          q.push_back('{gi, model_a(req_z[8*gi +: 8]), 1});
          m_last = gi;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_single(input int id, input logic [7:0] z, input int exp);
    int ok;
    ok = 0;
    req_z[8*id +: 8] = z;
    req_valid[id]    = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1;
        break;
      end
    end
    chk("single_grant", ok, 1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    @(negedge clk);
    chk("single_stageA_only", int'(res_valid), 0);
    chk("single_pulse", int'(req_ready), 0);
    @(negedge clk);
    chk("single_valid", int'(res_valid), 1);
    chk("single_a", int'(res_a), exp);
    chk("single_id", int'(res_id), id);
    @(posedge clk);
    #1;
  endtask

  // Retire outstanding requests without violating the hold-until-transfer rule.
  task automatic drain();
    logic [N-1:0] gr;
    res_ready = 1'b1;
    for (int c = 0; c < 60 && req_valid != '0; c++) begin
      @(negedge clk);
      gr = req_ready;
      @(posedge clk);
      #1 req_valid = req_valid & ~gr;
    end
    chk("drain_done", int'(req_valid), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] gr;
    int n, got, n2;
    rst       = 1'b1;
    req_valid = '0;
    req_z     = '0;
    res_ready = 1'b1;
    for (int k = 0; k <= 16; k++)
      tbl[k] = int'($floor(64.0 / (1.0 + $exp(-real'(k - 8))) + 0.5));

    // pin the reference model
    chk("model_t7", tbl[7], 17);
    chk("model_t9", tbl[9], 47);
    chk("model_t10", tbl[10], 56);
    chk("model_z18", model_a(8'h18), 51);
    chk("model_zF8", model_a(8'hF8), 24);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_res_a", int'(res_a), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    do_single(0, 8'h00, 32);
    do_single(1, 8'h18, 51);
    do_single(2, 8'hF8, 24);
    do_single(3, 8'h80, 0);
    do_single(0, 8'h7F, 64);

    // all requesters continuously valid
    reset_dut();
    for (int i = 0; i < N; i++) req_z[8*i +: 8] = 8'($urandom);
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("rr_order", int'(req_ready), 1 << (c % N));
      gr = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (gr[i]) req_z[8*i +: 8] = 8'($urandom);
    end
    drain();

    // stall with four pending requests
    reset_dut();
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) req_z[8*i +: 8] = 8'($urandom);
    req_valid = '1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n += $countones(req_ready);
      gr = req_ready;
      @(posedge clk);
      #1 req_valid = req_valid & ~gr;
    end
    chk("stall_items", n, 2);
    @(negedge clk);
    chk("stall_ready", int'(req_ready), 0);
    chk("stall_busy", int'(busy), 1);
    @(posedge clk);
    #1 res_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < N; c++) begin
      @(negedge clk);
      if (c == 0) chk("release_grant", int'(req_ready), 4'b0100);
      if (res_valid) begin
        chk("stall_order", int'(res_id), got);
        got++;
      end
      gr = req_ready;
      @(posedge clk);
      #1 req_valid = req_valid & ~gr;
    end
    chk("stall_count", got, N);
    drain();

    // reset while both stages hold data
    res_ready = 1'b0;
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", int'(res_valid), 1);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("async_res_valid", int'(res_valid), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_req_ready", int'(req_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    res_ready = 1'b1;
    req_valid = '1;
    @(negedge clk);
    chk("post_rst_first", int'(req_ready), 1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    drain();

    // requester 2 back-to-back while requester 1 toggles
    req_valid = 4'b0100;
    n2 = 0;
    for (int c = 0; c < 100 && n2 < 10; c++) begin
      @(negedge clk);
      gr = req_ready;
      if (gr[2]) n2++;
      @(posedge clk);
      #1;
      if (gr[2]) req_z[8*2 +: 8] = 8'($urandom);
      if (gr[1]) req_z[8*1 +: 8] = 8'($urandom);
      if (!req_valid[1]) req_valid[1] = 1'b1;
      else if (gr[1]) req_valid[1] = 1'b0;
    end
    chk("req2_count", n2, 10);
    req_valid[2] = req_valid[2] & ~gr[2];
    drain();

    // randomized traffic with backpressure
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      gr = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (gr[i] || !req_valid[i]) begin
          req_valid[i]     = ($urandom_range(0, 2) != 0);
          req_z[8*i +: 8]  = 8'($urandom);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    drain();
    @(negedge clk);
    chk("final_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
